memory_responder: RTL and testbench

//  Memory-side end of the cache fill protocol: receives memory_request/memory_address

---
 rtl/memory_responder.sv | 75 +++++++
 tb/tb_memory_responder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// memory_responder: memory endpoint with pipelined reads and stalling single-word writes.
// Define MEM_RESPONDER_ECHO_ADDR_EN to add the data_address echo port.
module memory_responder #(
  parameter int ADDR_BITS    = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int LATENCY      = 4,
  parameter int WRITE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memory_request,
  input  logic [ADDR_BITS-1:0]  memory_address,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  memory_stall
`ifdef MEM_RESPONDER_ECHO_ADDR_EN
  ,
  output logic [ADDR_BITS-1:0]  data_address
`endif
);
  localparam int CW = WRITE_CYCLES > 1 ? $clog2(WRITE_CYCLES) : 1;
  logic [DATA_WIDTH-1:0] r_mem [2**(ADDR_BITS-1)];
  logic [LATENCY-1:0]    r_vld;
  logic [DATA_WIDTH-1:0] r_dat [LATENCY];
  logic [CW-1:0]         r_wcnt;
  logic                  r_stall;
  logic [ADDR_BITS-2:0]  w_idx;
  logic [CW-1:0]         w_wcnt_nxt;
  logic                  w_acc, w_rd, w_wr, w_unused;
  assign w_idx      = memory_address[ADDR_BITS-1:1];
  assign w_unused   = memory_address[0];
  assign w_acc      = memory_request & ~r_stall;
  assign w_rd       = w_acc & ~write_enable;
  assign w_wr       = w_acc & write_enable;
  assign w_wcnt_nxt = w_wr ? CW'(WRITE_CYCLES - 1) : (r_wcnt != '0 ? r_wcnt - 1'b1 : '0);
  assign data_out     = r_dat[LATENCY-1];
  assign data_valid   = r_vld[LATENCY-1];
  assign memory_stall = r_stall;
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_idx] <= data_in;
  end
  // Data stages only advance behind a valid bit, so data_out holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= '0;
      r_wcnt  <= '0;
      r_stall <= 1'b0;
      for (int i = 0; i < LATENCY; i++) r_dat[i] <= '0;
    end else begin
      r_vld[0] <= w_rd;
      if (w_rd) r_dat[0] <= r_mem[w_idx];
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) r_dat[i] <= r_dat[i-1];
      end
      r_wcnt  <= w_wcnt_nxt;
      r_stall <= w_wcnt_nxt != '0;
    end
  end
`ifdef MEM_RESPONDER_ECHO_ADDR_EN
  logic [ADDR_BITS-1:0] r_adr [LATENCY];
  assign data_address = r_adr[LATENCY-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) r_adr[i] <= '0;
    end else begin
      if (w_rd) r_adr[0] <= memory_address;
      for (int i = 1; i < LATENCY; i++)
        if (r_vld[i-1]) r_adr[i] <= r_adr[i-1];
    end
  end
`endif
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed scoreboard bench for memory_responder.
module tb_memory_responder;
  localparam int LAT = 4;
  localparam int WC  = 4;
  typedef struct {
    logic [15:0] d;
    logic [15:0] a;
    int          due;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        memory_request, write_enable;
  logic [15:0] memory_address, data_in, data_out;
  logic        data_valid, memory_stall;
`ifdef MEM_RESPONDER_ECHO_ADDR_EN
  logic [15:0] data_address;
`endif
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        q[$];
  logic [15:0] mdl [int];
  memory_responder #(.ADDR_BITS(16), .DATA_WIDTH(16), .LATENCY(LAT), .WRITE_CYCLES(WC)) dut (
    .clk(clk), .rst_n(rst_n), .memory_request(memory_request), .memory_address(memory_address),
    .write_enable(write_enable), .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
    .memory_stall(memory_stall)
`ifdef MEM_RESPONDER_ECHO_ADDR_EN
    , .data_address(data_address)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Every negedge: data_valid must match the scoreboard head's due cycle exactly.
  always @(negedge clk) begin
    bit ev;
    ev = q.size() > 0 && q[0].due == cyc;
    n_chk++;
    assert (data_valid === ev) else begin
      n_fail++;
      $error("FAIL data_valid cyc=%0d observed=%b expected=%b", cyc, data_valid, ev);
    end
    if (ev && data_valid) begin
      n_chk++;
      assert (data_out === q[0].d) else begin
        n_fail++;
        $error("FAIL data_out addr=%h observed=%h expected=%h", q[0].a, data_out, q[0].d);
      end
`ifdef MEM_RESPONDER_ECHO_ADDR_EN
      n_chk++;
      assert (data_address === q[0].a) else begin
        n_fail++;
        $error("FAIL data_address observed=%h expected=%h", data_address, q[0].a);
      end
`endif
    end
    while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
  end
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic we, input logic [15:0] a, input logic [15:0] d, input bit acc);
    memory_request = 1'b1;
    write_enable   = we;
    memory_address = a;
    data_in        = d;
    if (acc) begin
      if (we) mdl[int'(a[15:1])] = d;
      else q.push_back(exp_t'{mdl[int'(a[15:1])], a, cyc + LAT});
    end
    @(negedge clk);
    memory_request = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    req(1'b1, a, d, 1'b1);
    idle(WC - 1);
  endtask
  initial begin
    memory_request = 1'b0;
    write_enable   = 1'b0;
    memory_address = '0;
    data_in        = '0;
    rst_n          = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_valid", {15'd0, data_valid}, 16'd0);
    chk("reset_stall", {15'd0, memory_stall}, 16'd0);
    chk("reset_data", data_out, 16'd0);
    idle(2);
    rst_n = 1'b1;
    wr(16'h0010, 16'hBEEF);
    req(1'b0, 16'h0010, 16'h0, 1'b1);
    idle(LAT - 2);
    chk("single_early", {15'd0, data_valid}, 16'd0);
    idle(1);
    chk("single_valid", {15'd0, data_valid}, 16'd1);
    chk("single_data", data_out, 16'hBEEF);
    for (int i = 0; i < 8; i++) wr(16'h0020 + 16'(2 * i), 16'hA000 + 16'(i * 16'h0111));
    for (int i = 0; i < 8; i++) req(1'b0, 16'h0020 + 16'(2 * i), 16'h0, 1'b1);
    idle(LAT);
    req(1'b1, 16'h0040, 16'h1234, 1'b1);
    chk("stall_1", {15'd0, memory_stall}, 16'd1);
    req(1'b0, 16'h0040, 16'h0, 1'b0);
    chk("stall_2", {15'd0, memory_stall}, 16'd1);
    req(1'b0, 16'h0040, 16'h0, 1'b0);
    chk("stall_3", {15'd0, memory_stall}, 16'd1);
    req(1'b0, 16'h0040, 16'h0, 1'b0);
    chk("stall_end", {15'd0, memory_stall}, 16'd0);
    req(1'b0, 16'h0040, 16'h0, 1'b1);
    idle(LAT);
    wr(16'h0050, 16'hAAAA);
    req(1'b0, 16'h0050, 16'h0, 1'b1);
    req(1'b0, 16'h0010, 16'h0, 1'b1);
    req(1'b1, 16'h0050, 16'h5555, 1'b1);
    idle(WC - 1);
    req(1'b0, 16'h0050, 16'h0, 1'b1);
    idle(LAT);
    req(1'b0, 16'h0011, 16'h0, 1'b1);
    req(1'b0, 16'h0010, 16'h0, 1'b1);
    wr(16'hFFFE, 16'hCAFE);
    wr(16'h7FFE, 16'h1111);
    req(1'b0, 16'hFFFF, 16'h0, 1'b1);
    req(1'b0, 16'hFFFE, 16'h0, 1'b1);
    req(1'b0, 16'h7FFE, 16'h0, 1'b1);
    idle(LAT);
    req(1'b0, 16'h0020, 16'h0, 1'b1);
    req(1'b0, 16'h0022, 16'h0, 1'b1);
    req(1'b0, 16'h0024, 16'h0, 1'b1);
    req(1'b1, 16'h0060, 16'h9999, 1'b1);
    chk("pre_reset_stall", {15'd0, memory_stall}, 16'd1);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_valid", {15'd0, data_valid}, 16'd0);
    chk("midrst_stall", {15'd0, memory_stall}, 16'd0);
    chk("midrst_data", data_out, 16'd0);
    idle(2);
    rst_n = 1'b1;
    idle(LAT + 2);
    chk("post_rst_stall", {15'd0, memory_stall}, 16'd0);
    req(1'b0, 16'h0060, 16'h0, 1'b1);
    idle(LAT + 1);
    n_chk++;
    assert (q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
